// File: rtl/lcd_host_seq_if.sv
// Bus bundle between the LCD host sequencer, its command ROM,
// the LCD controller and the image-buffer write port.
interface lcd_host_seq_if;
  logic        start;
  logic        CROM_EN;
  logic [4:0]  CROM_A;
  logic [3:0]  CROM_Q;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic        busy;
  logic        done;
  logic        IRB_RW;
  logic [5:0]  IRB_A;
  logic [7:0]  IRB_D;
  logic [13:0] img_sum;
  logic [6:0]  wr_count;
  logic        fin;
  logic        err;

  // Sequencer side: drives ROM reads, LCD commands and status.
  modport master (
    input  start, CROM_Q, busy, done, IRB_RW, IRB_A, IRB_D,
    output CROM_EN, CROM_A, cmd, cmd_valid, img_sum, wr_count, fin, err
  );

  // Environment side: ROM, LCD controller and the host.
  modport slave (
    output start, CROM_Q, busy, done, IRB_RW, IRB_A, IRB_D,
    input  CROM_EN, CROM_A, cmd, cmd_valid, img_sum, wr_count, fin, err
  );
endinterface

// File: rtl/lcd_host_seq.sv
// LCD host sequencer: walks a command-ROM script, issues each opcode to the
// LCD controller when it is idle, waits (with a watchdog) for the image Write
// to complete, and in parallel sums and counts image-buffer writes.
module lcd_host_seq (
  input  logic           clk,
  input  logic           rst_n,
  lcd_host_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    WAIT_DONE,
    FINISH
  } state_t;

  localparam logic [7:0] WDOG_LIMIT = 8'd200;
  localparam logic [6:0] MAX_WRITES = 7'd64;
  localparam logic [4:0] LAST_ADDR  = 5'd31;

  state_t      state_q, state_d;
  logic        crom_en_q, crom_en_d;
  logic [4:0]  crom_a_q, crom_a_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [13:0] img_sum_q, img_sum_d;
  logic [6:0]  wr_count_q, wr_count_d;
  logic        fin_q, fin_d;
  logic        err_q, err_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [2:0]  opcode_q, opcode_d;
  logic        last_q, last_d;
  logic        restart;

  // Next-state logic: image capture first, then the script FSM, with a
  // restart clear applied last so it overrides a same-cycle capture.
  always_comb begin
    state_d     = state_q;
    crom_en_d   = crom_en_q;
    crom_a_d    = crom_a_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    img_sum_d   = img_sum_q;
    wr_count_d  = wr_count_q;
    fin_d       = fin_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    opcode_d    = opcode_q;
    last_d      = last_q;
    restart     = 1'b0;

    if (!bus.IRB_RW) begin
      if (wr_count_q == MAX_WRITES) begin
        err_d = 1'b1;
      end else begin
        img_sum_d  = img_sum_q + {6'd0, bus.IRB_D};
        wr_count_d = wr_count_q + 7'd1;
        if (bus.IRB_A != wr_count_q[5:0]) begin
          err_d = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        crom_en_d = 1'b1;
        restart   = bus.start;
      end
      FETCH: begin
        crom_en_d = 1'b1;
        state_d   = LATCH;
      end
      LATCH: begin
        opcode_d = bus.CROM_Q[2:0];
        last_d   = bus.CROM_Q[3];
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (!bus.busy) begin
          cmd_d       = opcode_q;
          cmd_valid_d = 1'b1;
          if (opcode_q == 3'b000) begin
            if (!last_q) begin
              err_d = 1'b1;
            end
            wdog_d  = 8'd0;
            state_d = WAIT_DONE;
          end else if (last_q || (crom_a_q == LAST_ADDR)) begin
            err_d   = 1'b1;
            fin_d   = 1'b1;
            state_d = FINISH;
          end else begin
            crom_a_d  = crom_a_q + 5'd1;
            crom_en_d = 1'b0;
            state_d   = FETCH;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.done) begin
          fin_d   = 1'b1;
          state_d = FINISH;
        end else if (wdog_q == WDOG_LIMIT - 8'd1) begin
          wdog_d  = WDOG_LIMIT;
          err_d   = 1'b1;
          fin_d   = 1'b1;
          state_d = FINISH;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      FINISH: begin
        fin_d     = 1'b1;
        crom_en_d = 1'b1;
        restart   = bus.start;
      end
      default: begin
        state_d   = IDLE;
        crom_en_d = 1'b1;
      end
    endcase

    if (restart) begin
      state_d    = FETCH;
      crom_a_d   = 5'd0;
      crom_en_d  = 1'b0;
      img_sum_d  = 14'd0;
      wr_count_d = 7'd0;
      err_d      = 1'b0;
      fin_d      = 1'b0;
      wdog_d     = 8'd0;
    end
  end

  // State and output registers; reset aborts any script immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crom_en_q   <= 1'b1;
      crom_a_q    <= 5'd0;
      cmd_q       <= 3'b001;
      cmd_valid_q <= 1'b0;
      img_sum_q   <= 14'd0;
      wr_count_q  <= 7'd0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
      wdog_q      <= 8'd0;
      opcode_q    <= 3'b001;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      crom_en_q   <= crom_en_d;
      crom_a_q    <= crom_a_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      img_sum_q   <= img_sum_d;
      wr_count_q  <= wr_count_d;
      fin_q       <= fin_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
      opcode_q    <= opcode_d;
      last_q      <= last_d;
    end
  end

  assign bus.CROM_EN   = crom_en_q;
  assign bus.CROM_A    = crom_a_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.img_sum   = img_sum_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.fin       = fin_q;
  assign bus.err       = err_q;

endmodule

// File: doc/lcd_host_seq.md
LCD_HOST_SEQ -- requirements
Module: lcd_host_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  begin script execution; sampled only in IDLE or FINISH.
REQ-004 CROM_EN  output  1  command-ROM read enable, 0 = read, 1 = closed.
REQ-005 CROM_A  output  5  command-ROM address (32 entries).
REQ-006 CROM_Q  input  4  ROM data, valid at the edge after the one where CROM_EN=0; bit3 = last, bits2:0 = opcode.
REQ-007 cmd  output  3  opcode to LCD controller (000 Write, 001-111 shift/average/mirror).
REQ-008 cmd_valid  output  1  one-cycle command strobe.
REQ-009 busy  input  1  LCD controller busy; a command is issued only while 0.
REQ-010 done  input  1  LCD controller finished image write.
REQ-011 IRB_RW  input  1  image-buffer write strobe, 0 = write this cycle.
REQ-012 IRB_A  input  6  image-buffer write address.
REQ-013 IRB_D  input  8  image-buffer write data.
REQ-014 img_sum  output  14  unsigned sum of captured IRB_D bytes.
REQ-015 wr_count  output  7  number of captured writes, 0..64.
REQ-016 fin  output  1  script complete, held until restart.
REQ-017 err  output  1  protocol/script error, sticky until restart.

Function
REQ-018 All outputs registered; FSM states IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, FINISH.
REQ-019 IDLE: CROM_EN=1; start=1 -> FETCH, CROM_A<=0, img_sum/wr_count/err/fin cleared.
REQ-020 FETCH: CROM_EN=0 for exactly one cycle -> LATCH.
REQ-021 LATCH: CROM_EN=1, opcode/last captured from CROM_Q -> ISSUE.
REQ-022 ISSUE: wait with cmd_valid=0 while busy=1; at first edge with busy=0, cmd<=opcode and cmd_valid<=1 for one cycle.
REQ-023 After issue: opcode 000 -> WAIT_DONE; else last=1 -> FINISH with err<=1 (no Write); else CROM_A+1 -> FETCH.
REQ-024 Opcode 000 with last=0 is accepted; err<=1, entries after it are not fetched.
REQ-025 Non-Write entry at CROM_A=31 with last=0: err<=1 -> FINISH (no address wrap).
REQ-026 cmd is never 000 unless a Write is issued; reset value of cmd is 001 and cmd holds its last issued value between strobes.
REQ-027 WAIT_DONE: 8-bit watchdog counts from 0; done=1 -> FINISH; count reaching 200 before done -> err<=1, FINISH.
REQ-028 FINISH: fin=1, CROM_EN=1, cmd_valid=0; start=1 -> same action as IDLE start (REQ-019).
REQ-029 start in FETCH/LATCH/ISSUE/WAIT_DONE ignored.
REQ-030 IRB capture in every state: edge with IRB_RW=0 -> img_sum<=img_sum+IRB_D, wr_count<=wr_count+1.
REQ-031 Capture address check: IRB_A != wr_count[5:0] at capture -> err<=1 (capture still counted).
REQ-032 Capture with wr_count=64 -> err<=1, wr_count and img_sum unchanged (saturate).
REQ-033 Restart clear (REQ-019) and a simultaneous capture: clear wins, capture dropped.
REQ-034 Latency: start sampled at edge E0 -> CROM_EN=0 after E0, opcode latched at E2, cmd_valid=1 after E3 if busy=0 at E3.

Reset
REQ-035 reset=0 asynchronously forces IDLE, CROM_EN=1, CROM_A=0, cmd=001, cmd_valid=0, img_sum=0, wr_count=0, fin=0, err=0, watchdog=0.
REQ-036 reset asserted mid-script aborts immediately; no cmd_valid after release until a new start.

Verification
REQ-037 Script {011, 100, 101, 1000}, busy=0 -> cmd_valid pulses with cmd 011,100,101,000, each separated by FETCH+LATCH (3 cycles); fin=1 after done, err=0.
REQ-038 busy held 1 for 10 cycles in ISSUE -> cmd_valid stays 0, then single pulse on first busy=0 edge.
REQ-039 64 writes IRB_A=0..63, IRB_D=255 -> img_sum=16320, wr_count=64, err=0; 65th write -> err=1, values unchanged.
REQ-040 Write issued, done never asserted -> err=1, fin=1 at watchdog=200.
REQ-041 Script with last=1 on opcode 111 -> err=1, fin=1, no Write issued, cmd never 000.
REQ-042 reset=0 during WAIT_DONE -> all outputs at REQ-035 values same cycle; start after release restarts at CROM_A=0.
